// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared constants for the RV32 ALU control decoder and the iterative mul/div unit.
package alu_ctrl_mdu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/alu_ctrl_mdu_mdu_iterative.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply and restoring divide
// over operand magnitudes, with sign fix-up folded into the final iteration.
module mdu_iterative
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output mdu_state_t      state,
  output logic            result_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic [2:0]        op_reg;
  logic              neg_reg, neg_rem_reg, special_reg;

  // Operand conditioning, evaluated in the accepting cycle.
  logic              is_div, a_signed, b_signed, a_neg, b_neg, special;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] special_acc;

  always_comb begin
    is_div   = funct3[2];
    a_signed = is_div ? ~funct3[0] : (funct3 != F3_MULHU);
    b_signed = is_div ? ~funct3[0] : (funct3 == F3_MUL || funct3 == F3_MULH);
    a_neg    = a_signed & src_a[XLEN-1];
    b_neg    = b_signed & src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    special  = 1'b0;
    special_acc = '0;
    // Accumulator holds {remainder, quotient} so the special results drop straight out.
    if (is_div && src_b == '0) begin
      special     = 1'b1;
      special_acc = {src_a, {XLEN{1'b1}}};
    end else if (is_div && ~funct3[0] && src_a == MIN_NEG && src_b == '1) begin
      special     = 1'b1;
      special_acc = {{XLEN{1'b0}}, src_a};
    end
  end

  // One iteration step of the active operation.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res, special_res;
  logic              last_iter;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_trial = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, opnd_reg};
    if (!op_reg[2])
      acc_step = {mul_sum, acc_reg[XLEN-1:1]};
    else if (!div_trial[XLEN])
      acc_step = {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    else
      acc_step = {acc_reg[2*XLEN-2:0], 1'b0};
    prod_fix = neg_reg ? -acc_step : acc_step;
    quo_fix  = neg_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_rem_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (!op_reg[2])
      final_res = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      final_res = op_reg[1] ? rem_fix : quo_fix;
    special_res = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
    last_iter   = (count_reg == CNT_W'(XLEN-1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = funct3[2] ? ST_DIV : ST_MUL;
      ST_MUL:  if (last_iter) state_next = ST_DONE;
      ST_DIV:  if (special_reg || last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    state        = state_reg;
    result_valid = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      neg_rem_reg <= 1'b0;
      special_reg <= 1'b0;
      mdu_result  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          op_reg      <= funct3;
          count_reg   <= '0;
          neg_reg     <= a_neg ^ b_neg;
          neg_rem_reg <= a_neg;
          special_reg <= special;
          if (special) begin
            acc_reg  <= special_acc;
            opnd_reg <= '0;
          end else if (is_div) begin
            acc_reg  <= {{XLEN{1'b0}}, a_mag};
            opnd_reg <= b_mag;
          end else begin
            acc_reg  <= {{XLEN{1'b0}}, b_mag};
            opnd_reg <= a_mag;
          end
        end
        ST_MUL, ST_DIV: begin
          if (state_reg == ST_DIV && special_reg) begin
            mdu_result <= special_res;
          end else begin
            acc_reg   <= acc_step;
            count_reg <= count_reg + CNT_W'(1);
            if (last_iter) mdu_result <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode for the single-cycle RV32 core plus stall/writeback steering
// for the iterative multiply/divide unit.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op5,
  input  logic                  funct7_5,
  input  logic                  funct7_0,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  mdu_sel,
  output logic                  stall,
  output logic                  result_valid,
  output logic [XLEN-1:0]       mdu_result
);

  logic       is_m;
  logic [3:0] code;
  mdu_state_t state;

  assign is_m = (alu_op == ALUOP_FUNCT) & op5 & funct7_0;

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   code = ALU_ADD;
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_PASSB: code = ALU_PASSB;
      default: begin
        case (funct3)
          3'b000:  code = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
    if (is_m) code = ALU_ADD;
  end

  assign alu_control = ALU_CTRL_W'(code);

  // The DONE cycle drops stall so the core commits and advances PC on that edge.
  assign stall   = ~reset & valid_in & is_m & (state != ST_DONE);
  assign mdu_sel = ~reset & is_m;

  mdu_iterative #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk          (clk),
    .reset        (reset),
    .start        (valid_in & is_m),
    .funct3       (funct3),
    .src_a        (src_a),
    .src_b        (src_b),
    .state        (state),
    .result_valid (result_valid),
    .mdu_result   (mdu_result)
  );

endmodule
